cam_pix_capture: RTL and testbench
==================================

CAM_PIX_CAPTURE -- requirements
Module: cam_pix_capture

Interface
REQ-001 Parameter H_RES, default 640, active pixels per camera line.
REQ-002 Parameter V_RES, default 480, active lines per camera frame.
REQ-003 Parameter CH_BITS, default 3, output bits per colour channel, legal range 1..4.
REQ-004 Parameter ADDR_W, default 19, width of the write address.
REQ-005 i_clk  in  1  camera pixel clock; sole clock of the block.
REQ-006 i_rst  in  1  asynchronous, active-high reset.
REQ-007 i_arm  in  1  single-cycle pulse that starts capture.
REQ-008 i_cfg_decim  in  2  downscale factor D: 00=1, 01=2, 10=4, 11=4.
REQ-009 i_cfg_fmt  in  1  input format: 0=RGB444, 1=RGB565.
REQ-010 i_cfg_snap  in  1  1=capture one frame then stop; 0=continuous.
REQ-011 i_vsync  in  1  camera vsync; high during vertical blanking.
REQ-012 i_href  in  1  camera href; high while line bytes are valid.
REQ-013 i_pix_byte  in  8  camera data byte.
REQ-014 o_pix_wr  out  1  BRAM write strobe.
REQ-015 o_pix_addr  out  ADDR_W  BRAM write address.
REQ-016 o_pix_data  out  3*CH_BITS  packed pixel, {R,G,B}.
REQ-017 o_busy  out  1  high in any state other than IDLE.
REQ-018 o_frame_done  out  1  one-cycle pulse at the end of each captured frame.
REQ-019 o_frame_cnt  out  8  count of completed frames; wraps from 255 to 0.
REQ-020 o_ovf  out  1  sticky error flag for an over-long line or frame.

Function
REQ-021 FSM states and transitions:
- IDLE: go to ARMED on i_arm.
- ARMED: go to CAPTURE on a falling edge of registered i_vsync.
- CAPTURE: go to FDONE on a rising edge of i_vsync.
- FDONE: lasts one cycle; go to IDLE if snap is 1, otherwise go to ARMED.
REQ-022 i_cfg_decim, i_cfg_fmt and i_cfg_snap SHALL be latched on the IDLE->ARMED and FDONE->ARMED transitions; changes at any other time SHALL have no effect until the next latch.
REQ-023 i_arm SHALL be ignored outside IDLE.
REQ-024 Byte pairing in CAPTURE:
- A byte phase toggle SHALL clear while i_href=0.
- The first href byte is HI; the next byte is LO; then pairing repeats.
REQ-025 RGB565 pixel fields: R=HI[7:3], G={HI[2:0],LO[7:5]}, B=LO[4:0].
REQ-026 RGB444 pixel fields: R=HI[3:0], G=LO[7:4], B=LO[3:0].
REQ-027 Each channel SHALL be reduced to CH_BITS by taking its CH_BITS MSBs; there SHALL be no rounding.
REQ-028 Column counter x:
- Increments once per completed pixel.
- Clears on the falling edge of i_href.
REQ-029 Row counter y:
- Increments on each falling edge of i_href.
- Clears on entry to CAPTURE.
REQ-030 A pixel SHALL be written only if all of the following hold: x mod D == 0, y mod D == 0, x < H_RES, and y < V_RES.
REQ-031 Address rules:
- o_pix_addr SHALL be 0 for the first written pixel of a frame.
- It SHALL increment by 1 after each write.
- It SHALL never exceed (H_RES/D)*(V_RES/D)-1.
REQ-032 Write latency: o_pix_wr SHALL assert exactly one cycle after the edge that samples the LO byte. o_pix_data and o_pix_addr SHALL be valid in the same cycle.
REQ-033 Overflow: o_ovf SHALL set if a pixel arrives with x >= H_RES or y >= V_RES. Such pixels SHALL be dropped, and o_ovf SHALL clear only on reset.
REQ-034 A LO byte missing at the href fall SHALL cause the orphan HI byte to be discarded, with no write.
REQ-035 o_frame_done SHALL pulse in the FDONE cycle.
REQ-036 o_frame_cnt SHALL increment in the FDONE cycle.
REQ-037 If i_vsync rises while the LO byte is pending, no write SHALL occur.

Reset
REQ-038 While i_rst=1, the following SHALL hold: state=IDLE; o_pix_wr=0; o_pix_addr=0; o_pix_data=0; o_busy=0; o_frame_done=0; o_frame_cnt=0; o_ovf=0; all counters 0.
REQ-039 Reset asserted mid-frame SHALL abort immediately, with no further writes.
REQ-040 After reset releases, the block SHALL require a new i_arm before capturing again.

Verification
REQ-041 RGB565 path:
- Stimulus: D=1, fmt=1, CH_BITS=3, H_RES=4, V_RES=2, snap=1; one frame with bytes HI=0xF8, LO=0x1F.
- Response: 8 writes, addr 0..7, data 9'b111_000_111; one o_frame_done; o_frame_cnt=1; returns to IDLE.
REQ-042 Decimation:
- Stimulus: D=2, H_RES=8, V_RES=4, full frame.
- Response: exactly 8 writes, addr 0..7, taken from even x on rows y=0 and y=2.
REQ-043 Over-long line:
- Stimulus: a line of H_RES+2 pixels.
- Response: extra pixels are not written; o_ovf=1 and stays set through the next frames.
REQ-044 Continuous mode:
- Stimulus: snap=0, 3 frames.
- Response: o_frame_cnt=3; o_busy stays high; addr restarts at 0 each frame.
REQ-045 Config latching:
- Stimulus: i_cfg_decim changed mid-CAPTURE.
- Response: the current frame uses the old D; the next frame uses the new D.
REQ-046 Reset mid-frame:
- Stimulus: i_rst pulsed at pixel 3.
- Response: all outputs 0; no writes until i_arm and a vsync falling edge occur.

Source files
------------

// File: rtl/cam_pix_capture.sv
// Camera pixel capture: pairs bytes from an 8-bit camera bus into RGB
// pixels, optionally decimates, and writes them to a frame buffer.
module cam_pix_capture #(
  parameter int H_RES   = 640,
  parameter int V_RES   = 480,
  parameter int CH_BITS = 3,
  parameter int ADDR_W  = 19
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_arm,
  input  logic [1:0]             i_cfg_decim,
  input  logic                   i_cfg_fmt,
  input  logic                   i_cfg_snap,
  input  logic                   i_vsync,
  input  logic                   i_href,
  input  logic [7:0]             i_pix_byte,
  output logic                   o_pix_wr,
  output logic [ADDR_W-1:0]      o_pix_addr,
  output logic [3*CH_BITS-1:0]   o_pix_data,
  output logic                   o_busy,
  output logic                   o_frame_done,
  output logic [7:0]             o_frame_cnt,
  output logic                   o_ovf
);

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    CAPTURE,
    FDONE
  } state_t;

  // counters saturate well above the active area so long lines never wrap
  localparam int XW = $clog2(H_RES + 2) + 1;
  localparam int YW = $clog2(V_RES + 2) + 1;

  localparam logic [XW-1:0] H_LIM = XW'(H_RES);
  localparam logic [YW-1:0] V_LIM = YW'(V_RES);

  function automatic logic [ADDR_W-1:0] last_addr(input int d);
    int n;
    n = (H_RES / d) * (V_RES / d) - 1;
    if (n < 0) n = 0;
    return ADDR_W'(n);
  endfunction

  localparam logic [ADDR_W-1:0] AMAX1 = last_addr(1);
  localparam logic [ADDR_W-1:0] AMAX2 = last_addr(2);
  localparam logic [ADDR_W-1:0] AMAX4 = last_addr(4);

  state_t state;
  state_t state_nx;

  logic              vs_q;
  logic              href_q;
  logic              vs_fall;
  logic              vs_rise;
  logic              href_fall;

  logic [1:0]        dec_q;
  logic              fmt_q;
  logic              snap_q;
  logic              cfg_latch;

  logic              phase;
  logic [7:0]        hi_q;
  logic [XW-1:0]     x;
  logic [YW-1:0]     y;
  logic [ADDR_W-1:0] addr;
  logic              full;

  logic              start;
  logic              cap_ok;
  logic              hi_ev;
  logic              pix_ev;
  logic [1:0]        dmask;
  logic [ADDR_W-1:0] amax;
  logic              on_grid;
  logic              in_range;
  logic              do_wr;
  logic              do_ovf;

  logic [7:0]        r8;
  logic [7:0]        g8;
  logic [7:0]        b8;
  logic [3*CH_BITS-1:0] pix;

  assign vs_fall   = vs_q & ~i_vsync;
  assign vs_rise   = ~vs_q & i_vsync;
  assign href_fall = href_q & ~i_href;

  assign start  = (state == ARMED) & vs_fall;
  // a frame ending on this edge swallows any half-received pixel
  assign cap_ok = (state == CAPTURE) & ~vs_rise;
  assign hi_ev  = cap_ok & i_href & ~phase;
  assign pix_ev = cap_ok & i_href & phase;

  assign cfg_latch = ((state == IDLE) & i_arm)
                   | ((state == FDONE) & ~snap_q);

  // decimation mask and last legal address for the latched factor
  always_comb begin
    dmask = 2'b00;
    amax  = AMAX1;
    unique case (dec_q)
      2'b00: begin
        dmask = 2'b00;
        amax  = AMAX1;
      end
      2'b01: begin
        dmask = 2'b01;
        amax  = AMAX2;
      end
      default: begin
        dmask = 2'b11;
        amax  = AMAX4;
      end
    endcase
  end

  assign on_grid  = ((x[1:0] & dmask) == 2'b00)
                  & ((y[1:0] & dmask) == 2'b00);
  assign in_range = (x < H_LIM) & (y < V_LIM);
  assign do_wr    = pix_ev & on_grid & in_range & ~full;
  assign do_ovf   = pix_ev & ~in_range;

  // left-align every channel to 8 bits, then keep the top CH_BITS
  always_comb begin
    r8 = 8'h00;
    g8 = 8'h00;
    b8 = 8'h00;
    if (fmt_q) begin
      r8 = {hi_q[7:3], 3'b000};
      g8 = {hi_q[2:0], i_pix_byte[7:5], 2'b00};
      b8 = {i_pix_byte[4:0], 3'b000};
    end else begin
      r8 = {hi_q[3:0], 4'h0};
      g8 = {i_pix_byte[7:4], 4'h0};
      b8 = {i_pix_byte[3:0], 4'h0};
    end
  end

  assign pix = {r8[7 -: CH_BITS], g8[7 -: CH_BITS], b8[7 -: CH_BITS]};

  // next-state and status outputs
  always_comb begin
    state_nx     = state;
    o_busy       = 1'b1;
    o_frame_done = 1'b0;
    unique case (state)
      IDLE: begin
        o_busy = 1'b0;
        if (i_arm) state_nx = ARMED;
      end
      ARMED: begin
        if (vs_fall) state_nx = CAPTURE;
      end
      CAPTURE: begin
        if (vs_rise) state_nx = FDONE;
      end
      FDONE: begin
        o_frame_done = 1'b1;
        state_nx     = snap_q ? IDLE : ARMED;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // state register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nx;
  end

  // previous vsync/href for edge detection
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      vs_q   <= 1'b0;
      href_q <= 1'b0;
    end else begin
      vs_q   <= i_vsync;
      href_q <= i_href;
    end
  end

  // configuration is frozen for the whole frame
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      dec_q  <= 2'b00;
      fmt_q  <= 1'b0;
      snap_q <= 1'b0;
    end else if (cfg_latch) begin
      dec_q  <= i_cfg_decim;
      fmt_q  <= i_cfg_fmt;
      snap_q <= i_cfg_snap;
    end
  end

  // HI/LO byte phase; an orphan HI byte is dropped when href falls
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      phase <= 1'b0;
      hi_q  <= 8'h00;
    end else begin
      if (cap_ok & i_href) phase <= ~phase;
      else                 phase <= 1'b0;
      if (hi_ev) hi_q <= i_pix_byte;
    end
  end

  // column and row position within the frame
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      x <= '0;
      y <= '0;
    end else if (start) begin
      x <= '0;
      y <= '0;
    end else if (state == CAPTURE) begin
      if (href_fall) begin
        x <= '0;
        if (~&y) y <= y + 1'b1;
      end else if (pix_ev) begin
        if (~&x) x <= x + 1'b1;
      end
    end
  end

  // write address, held at the last legal slot once reached
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      addr <= '0;
      full <= 1'b0;
    end else if (start) begin
      addr <= '0;
      full <= 1'b0;
    end else if (do_wr) begin
      if (addr == amax) full <= 1'b1;
      else              addr <= addr + 1'b1;
    end
  end

  // registered write port toward the frame buffer
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_pix_wr   <= 1'b0;
      o_pix_addr <= '0;
      o_pix_data <= '0;
    end else begin
      o_pix_wr <= do_wr;
      if (do_wr) begin
        o_pix_addr <= addr;
        o_pix_data <= pix;
      end
    end
  end

  // sticky overflow flag and completed-frame counter
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_ovf       <= 1'b0;
      o_frame_cnt <= 8'h00;
    end else begin
      if (do_ovf) o_ovf <= 1'b1;
      if (state == FDONE) o_frame_cnt <= o_frame_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_cam_pix_capture.sv
// Bench for cam_pix_capture: vector table of pixel formats plus
// hand-built frames for decimation, continuous mode, reset and overflow.
module tb_cam_pix_capture;

  localparam int H  = 8;
  localparam int V  = 4;
  localparam int CB = 3;
  localparam int AW = 19;

  logic            clk = 1'b0;
  logic            rst;
  logic            arm;
  logic [1:0]      decim;
  logic            fmt;
  logic            snap;
  logic            vsync;
  logic            href;
  logic [7:0]      pbyte;
  logic            wr;
  logic [AW-1:0]   waddr;
  logic [3*CB-1:0] wdata;
  logic            busy;
  logic            done;
  logic [7:0]      fcnt;
  logic            ovf;

  cam_pix_capture #(
    .H_RES(H), .V_RES(V), .CH_BITS(CB), .ADDR_W(AW)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_arm(arm),
    .i_cfg_decim(decim), .i_cfg_fmt(fmt), .i_cfg_snap(snap),
    .i_vsync(vsync), .i_href(href), .i_pix_byte(pbyte),
    .o_pix_wr(wr), .o_pix_addr(waddr), .o_pix_data(wdata),
    .o_busy(busy), .o_frame_done(done), .o_frame_cnt(fcnt),
    .o_ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [8:0]    data;
  } exp_t;

  typedef struct {
    logic       fmt;
    logic [7:0] hi;
    logic [7:0] lo;
    logic [8:0] exp;
  } vec_t;

  exp_t q[$];
  exp_t e;
  vec_t vt[6];

  int n_cmp  = 0;
  int n_bad  = 0;
  int n_wr   = 0;
  int n_done = 0;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // scoreboard: every write must match the oldest expected pixel
  always @(negedge clk) begin
    if (wr) begin
      n_wr++;
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: addr %0d data %0h expected none",
                 waddr, wdata);
      end else begin
        e = q.pop_front();
        check("wr_addr", 32'(waddr), 32'(e.addr));
        check("wr_data", 32'(wdata), 32'(e.data));
      end
    end
    if (done) n_done++;
  end

  task automatic arm_cfg(input logic [1:0] d, input logic f,
                         input logic s);
    decim = d;
    fmt   = f;
    snap  = s;
    arm   = 1'b1;
    tick();
    arm   = 1'b0;
  endtask

  task automatic push(input int a, input logic [8:0] d);
    exp_t t;
    t.addr = AW'(a);
    t.data = d;
    q.push_back(t);
  endtask

  // one camera frame; the model pushes every pixel it expects written
  task automatic run_frame(input int lines, input int npix,
                           input int npix0, input int d, input bit cst,
                           input logic [7:0] hc, input logic [7:0] lc,
                           input logic [8:0] ec, input int chg,
                           input bit noexp);
    int a;
    int np;
    logic [7:0] h;
    logic [7:0] l;
    logic [2:0] x3;
    logic [2:0] y3;
    a = 0;
    href  = 1'b0;
    vsync = 1'b1;
    repeat (4) tick();
    vsync = 1'b0;
    repeat (3) tick();
    for (int y = 0; y < lines; y++) begin
      if (chg >= 0 && y == 1) decim = 2'(chg);
      np = (y == 0) ? npix0 : npix;
      for (int x = 0; x < np; x++) begin
        x3 = 3'(x);
        y3 = 3'(y);
        h  = cst ? hc : {4'h0, x3, 1'b0};
        l  = cst ? lc : {y3, 1'b0, 4'h0};
        if (!noexp && x % d == 0 && y % d == 0 && x < H && y < V) begin
          push(a, cst ? ec : {x3, y3, 3'b000});
          a++;
        end
        href  = 1'b1;
        pbyte = h;
        tick();
        pbyte = l;
        tick();
      end
      href = 1'b0;
      repeat (3) tick();
    end
    vsync = 1'b1;
    repeat (4) tick();
  endtask

  task automatic check_idle_outputs(input string nm);
    check({nm, "_wr"},   32'(wr),    0);
    check({nm, "_addr"}, 32'(waddr), 0);
    check({nm, "_data"}, 32'(wdata), 0);
    check({nm, "_busy"}, 32'(busy),  0);
    check({nm, "_done"}, 32'(done),  0);
    check({nm, "_cnt"},  32'(fcnt),  0);
    check({nm, "_ovf"},  32'(ovf),   0);
  endtask

  int w0;
  int d0;
  int c0;

  initial begin
    vt[0] = '{1'b1, 8'hF8, 8'h1F, 9'h1C7};
    vt[1] = '{1'b1, 8'h07, 8'hE0, 9'h038};
    vt[2] = '{1'b0, 8'h0F, 8'h00, 9'h1C0};
    vt[3] = '{1'b0, 8'hF5, 8'hA3, 9'h0A9};
    vt[4] = '{1'b1, 8'hA5, 8'h5A, 9'h16E};
    vt[5] = '{1'b0, 8'h00, 8'hFF, 9'h03F};

    rst   = 1'b1;
    arm   = 1'b0;
    decim = 2'b00;
    fmt   = 1'b0;
    snap  = 1'b1;
    vsync = 1'b0;
    href  = 1'b0;
    pbyte = 8'h00;
    repeat (3) tick();
    check_idle_outputs("reset");
    rst = 1'b0;
    tick();

    // pixel format table, one full snapshot frame per vector
    for (int i = 0; i < 6; i++) begin
      w0 = n_wr;
      d0 = n_done;
      arm_cfg(2'b00, vt[i].fmt, 1'b1);
      check("vec_armed_busy", 32'(busy), 1);
      run_frame(V, H, H, 1, 1'b1, vt[i].hi, vt[i].lo, vt[i].exp, -1, 1'b0);
      check("vec_writes", n_wr - w0, H * V);
      check("vec_done", n_done - d0, 1);
      check("vec_cnt", 32'(fcnt), i + 1);
      check("vec_idle", 32'(busy), 0);
      check("vec_pending", q.size(), 0);
    end

    // 2x decimation: even columns of rows 0 and 2
    w0 = n_wr;
    arm_cfg(2'b01, 1'b0, 1'b1);
    run_frame(V, H, H, 2, 1'b0, 8'h00, 8'h00, 9'h000, -1, 1'b0);
    check("dec2_writes", n_wr - w0, 8);
    check("dec2_last_addr", 32'(waddr), 7);
    check("dec2_pending", q.size(), 0);

    // continuous mode; decimation changed mid-frame applies next frame
    w0 = n_wr;
    d0 = n_done;
    c0 = fcnt;
    arm_cfg(2'b01, 1'b0, 1'b0);
    run_frame(V, H, H, 2, 1'b0, 8'h00, 8'h00, 9'h000, 0, 1'b0);
    check("cont_busy1", 32'(busy), 1);
    run_frame(V, H, H, 1, 1'b0, 8'h00, 8'h00, 9'h000, -1, 1'b0);
    check("cont_busy2", 32'(busy), 1);
    run_frame(V, H, H, 1, 1'b0, 8'h00, 8'h00, 9'h000, -1, 1'b0);
    check("cont_busy3", 32'(busy), 1);
    check("cont_cnt", 32'(fcnt), 32'(8'(c0 + 3)));
    check("cont_done", n_done - d0, 3);
    check("cont_writes", n_wr - w0, 8 + 2 * H * V);
    check("cont_pending", q.size(), 0);

    rst = 1'b1;
    tick();
    check_idle_outputs("rst2");
    rst = 1'b0;
    tick();

    // reset while pixel 3 is half received
    w0 = n_wr;
    arm_cfg(2'b00, 1'b1, 1'b1);
    vsync = 1'b1;
    repeat (4) tick();
    vsync = 1'b0;
    repeat (3) tick();
    href = 1'b1;
    for (int x = 0; x < 3; x++) begin
      push(x, 9'h1C7);
      pbyte = 8'hF8;
      tick();
      pbyte = 8'h1F;
      tick();
    end
    pbyte = 8'hF8;
    tick();
    rst = 1'b1;
    #1;
    check_idle_outputs("midrst");
    tick();
    tick();
    href = 1'b0;
    rst  = 1'b0;
    tick();
    check("midrst_writes", n_wr - w0, 3);
    run_frame(V, H, H, 1, 1'b1, 8'hF8, 8'h1F, 9'h1C7, -1, 1'b1);
    check("noarm_writes", n_wr - w0, 3);
    check("noarm_busy", 32'(busy), 0);
    arm_cfg(2'b00, 1'b1, 1'b1);
    run_frame(V, H, H, 1, 1'b1, 8'hF8, 8'h1F, 9'h1C7, -1, 1'b0);
    check("rearm_writes", n_wr - w0, 3 + H * V);
    check("rearm_pending", q.size(), 0);

    // orphan HI at href fall, then vsync rising with LO pending
    w0 = n_wr;
    d0 = n_done;
    arm_cfg(2'b00, 1'b1, 1'b1);
    vsync = 1'b1;
    repeat (4) tick();
    vsync = 1'b0;
    repeat (3) tick();
    push(0, 9'h1C7);
    href = 1'b1;
    pbyte = 8'hF8; tick();
    pbyte = 8'h1F; tick();
    pbyte = 8'hF8; tick();
    href = 1'b0;
    repeat (3) tick();
    push(1, 9'h038);
    href = 1'b1;
    pbyte = 8'h07; tick();
    pbyte = 8'hE0; tick();
    pbyte = 8'hF8; tick();
    pbyte = 8'h1F;
    vsync = 1'b1;
    tick();
    href = 1'b0;
    repeat (4) tick();
    check("orphan_writes", n_wr - w0, 2);
    check("orphan_done", n_done - d0, 1);
    check("orphan_idle", 32'(busy), 0);
    check("orphan_pending", q.size(), 0);

    // over-long first line: extra pixels dropped, flag sticks
    check("ovf_before", 32'(ovf), 0);
    w0 = n_wr;
    arm_cfg(2'b00, 1'b0, 1'b1);
    run_frame(V, H, H + 2, 1, 1'b0, 8'h00, 8'h00, 9'h000, -1, 1'b0);
    check("ovf_set", 32'(ovf), 1);
    check("ovf_writes", n_wr - w0, H * V);
    arm_cfg(2'b00, 1'b0, 1'b1);
    run_frame(V, H, H, 1, 1'b0, 8'h00, 8'h00, 9'h000, -1, 1'b0);
    check("ovf_sticky", 32'(ovf), 1);
    check("ovf_pending", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
